mem_bist_wb: RTL and testbench

MEM_BIST_WB -- requirements
Module: mem_bist_wb

---
 rtl/mem_bist_wb.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_bist_wb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_wb.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_wb
// Description : Wishbone-master memory BIST. Writes a selectable pattern to
//               addresses 0..DEPTH-1, reads everything back, counts
//               mismatches and reports pass / timeout / first failing
//               address.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_wb #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int TIMEOUT = 255,
    parameter int ERR_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic              wb_cyc_o,
    output logic              wb_we_o,
    input  logic              wb_ack_i,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_datw_o,
    input  logic [DATA_W-1:0] wb_datr_i
);

    localparam int                c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [15:0]       c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0]       c_LFSR_MASK = 16'hB400;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    // Last wait value before the counter reaches TIMEOUT on the next edge
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    // 0101... with LSB = 1, trimmed to the data width
    localparam logic [DATA_W-1:0] c_ALT01     = DATA_W'({8{2'b01}});

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WGAP = 3'd2,
        S_RD   = 3'd3,
        S_RGAP = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_lfsr;
    logic [c_WAIT_W-1:0] r_wait;
    logic [ERR_W-1:0]    r_err;
    logic [ADDR_W-1:0]   r_fail;
    logic                r_pass;
    logic                r_timeout;
    logic                r_done;
    logic                r_busy;
    logic                r_cyc;
    logic                r_we;
    logic [DATA_W-1:0]   r_datw;

    logic                w_ack;
    logic [DATA_W-1:0]   w_expect;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [15:0]         w_lfsr_step;

    // One step of the 16-bit Galois LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? c_LFSR_MASK : 16'h0000);
    endfunction

    // Data pattern for a given mode, address and LFSR state
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [15:0]       l);
        logic [DATA_W-1:0] p;
        case (m)
            2'd1:    p = a[0] ? ~c_ALT01 : c_ALT01;
            2'd2:    p = DATA_W'(l);
            default: p = DATA_W'(a);
        endcase
        return p;
    endfunction

    // An ack only counts while this master owns the bus
    assign w_ack       = r_cyc & wb_ack_i;
    assign w_expect    = pattern(r_mode, r_addr, r_lfsr);
    assign w_addr_inc  = r_addr + 1'b1;
    assign w_lfsr_step = lfsr_step(r_lfsr);

    // Sequencer: start, write sweep, read-back sweep, one-cycle finish
    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'd0;
            r_addr    <= '0;
            r_lfsr    <= 16'h0000;
            r_wait    <= '0;
            r_err     <= '0;
            r_fail    <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_datw    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mode    <= mode_i;
                        r_err     <= '0;
                        r_fail    <= '0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_addr    <= '0;
                        r_lfsr    <= c_LFSR_SEED;
                        r_wait    <= '0;
                        r_datw    <= pattern(mode_i, '0, c_LFSR_SEED);
                        r_cyc     <= 1'b1;
                        r_we      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_ack) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_WGAP;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_cyc     <= 1'b0;
                        r_we      <= 1'b0;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WGAP: begin
                    r_wait <= '0;
                    r_cyc  <= 1'b1;
                    if (r_addr == c_LAST_ADDR) begin
                        r_addr  <= '0;
                        r_lfsr  <= c_LFSR_SEED;
                        r_we    <= 1'b0;
                        r_state <= S_RD;
                    end else begin
                        r_addr  <= w_addr_inc;
                        r_lfsr  <= w_lfsr_step;
                        r_datw  <= pattern(r_mode, w_addr_inc, w_lfsr_step);
                        r_we    <= 1'b1;
                        r_state <= S_WR;
                    end
                end
                S_RD: begin
                    if (w_ack) begin
                        if (wb_datr_i != w_expect) begin
                            if (r_err != '1) begin
                                r_err <= r_err + 1'b1;
                            end
                            if (r_err == '0) begin
                                r_fail <= r_addr;
                            end
                        end
                        r_cyc   <= 1'b0;
                        r_state <= S_RGAP;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_cyc     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RGAP: begin
                    if (r_addr == c_LAST_ADDR) begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_err == '0);
                        r_state <= S_FIN;
                    end else begin
                        r_addr  <= w_addr_inc;
                        r_lfsr  <= w_lfsr_step;
                        r_wait  <= '0;
                        r_cyc   <= 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign err_cnt_o   = r_err;
    assign fail_addr_o = r_fail;
    assign wb_cyc_o    = r_cyc;
    assign wb_we_o     = r_we;
    assign wb_addr_o   = r_addr;
    assign wb_datw_o   = r_datw;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bist_wb
// Description : Self-checking bench for mem_bist_wb with a Wishbone slave
//               memory model, fault injection and a pattern reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bist_wb;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int ERR_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic              busy_o, done_o, pass_o, timeout_o;
    logic [ERR_W-1:0]  err_cnt_o;
    logic [ADDR_W-1:0] fail_addr_o;
    logic              wb_cyc_o, wb_we_o;
    logic              wb_ack_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_datw_o;
    logic [DATA_W-1:0] wb_datr_i;
    logic [23:0]       all_outs;

    logic [7:0] mem   [DEPTH];
    logic [7:0] stuck [DEPTH];
    bit         corrupt;
    bit         stall_en;
    int         stall_addr;
    int         lat_fix;
    int         n_wr, n_rd, n_done;
    int         wcnt, cur_lat;
    int         vec, miss;

    always #5 clk = ~clk;

    mem_bist_wb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .ERR_W  (ERR_W)
    ) dut (
        .wb_clk_i   (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mode_i     (mode),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .timeout_o  (timeout_o),
        .err_cnt_o  (err_cnt_o),
        .fail_addr_o(fail_addr_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_we_o    (wb_we_o),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_datw_o  (wb_datw_o),
        .wb_datr_i  (wb_datr_i)
    );

    assign all_outs = {wb_cyc_o, wb_we_o, wb_addr_o, wb_datw_o, busy_o, done_o,
                       pass_o, timeout_o, err_cnt_o, fail_addr_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave memory: acks cur_lat cycles after cyc rises, optional stall and faults
    always @(negedge clk) begin
        if (rst || !wb_cyc_o) begin
            wb_ack_i = 1'b0;
            wcnt     = 0;
            cur_lat  = (lat_fix < 0) ? int'($urandom_range(7, 0)) : lat_fix;
        end else if (wb_ack_i) begin
            wb_ack_i = 1'b0;
        end else if (stall_en && wb_we_o && int'(wb_addr_o) == stall_addr) begin
            wb_ack_i = 1'b0;
        end else if (wcnt >= cur_lat) begin
            wb_ack_i = 1'b1;
            if (wb_we_o) begin
                mem[wb_addr_o] = wb_datw_o;
                n_wr++;
            end else begin
                wb_datr_i = (mem[wb_addr_o] | stuck[wb_addr_o]) ^ (corrupt ? 8'hFF : 8'h00);
                n_rd++;
            end
        end else begin
            wcnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst && done_o) n_done++;
    end

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'($urandom);
    endtask

    // Full run against the reference model; optionally pokes start while busy
    task automatic do_run(input logic [1:0] m, input bit poke);
        logic [7:0]  expv [DEPTH];
        logic [7:0]  rb;
        logic [15:0] l;
        int          e_err, e_fail;
        bit          got, poked;

        l = 16'hACE1;
        for (int a = 0; a < DEPTH; a++) begin
            case (m)
                2'd1:    expv[a] = (a % 2 == 1) ? 8'hAA : 8'h55;
                2'd2:    expv[a] = l[7:0];
                default: expv[a] = 8'(a);
            endcase
            l = (l >> 1) ^ ((l % 2 == 1) ? 16'hB400 : 16'h0000);
        end
        e_err  = 0;
        e_fail = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rb = (expv[a] | stuck[a]) ^ (corrupt ? 8'hFF : 8'h00);
            if (rb != expv[a]) begin
                if (e_err == 0) e_fail = a;
                e_err++;
            end
        end
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
        n_wr = 0; n_rd = 0; n_done = 0;

        pulse_start(m);
        got   = 1'b0;
        poked = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_o) got = 1'b1;
            else if (poke && !poked && n_rd == 5) begin
                start = 1'b1;
                mode  = 2'($urandom);
                poked = 1'b1;
            end
        end
        start = 1'b0;
        chk("run_done_seen", 32'(got), 32'd1);
        chk("run_pass",      32'(pass_o), 32'(e_err == 0));
        chk("run_err_cnt",   32'(err_cnt_o), 32'((e_err > 3) ? 3 : e_err));
        chk("run_fail_addr", 32'(fail_addr_o), 32'(e_fail));
        chk("run_timeout",   32'(timeout_o), 32'd0);
        chk("run_busy_fin",  32'(busy_o), 32'd1);
        @(negedge clk);
        chk("run_done_width", 32'(done_o), 32'd0);
        chk("run_busy_idle",  32'(busy_o), 32'd0);
        chk("run_done_count", 32'(n_done), 32'd1);
        chk("run_writes",     32'(n_wr), 32'(DEPTH));
        chk("run_reads",      32'(n_rd), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) chk($sformatf("mem_word_%0d", a), 32'(mem[a]), 32'(expv[a]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  run, cnt;
        bit  found;

        vec = 0; miss = 0;
        rst = 1'b1; start = 1'b0; mode = 2'd0;
        wb_ack_i = 1'b0; wb_datr_i = '0;
        corrupt = 1'b0; stall_en = 1'b0; stall_addr = 0; lat_fix = 1;
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = 8'h00;
            stuck[a] = 8'h00;
        end

        // Reset state and no activity without start
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cnt += int'(wb_cyc_o) + int'(busy_o);
        end
        chk("idle_after_reset", 32'(cnt), 32'd0);

        // Directed patterns, one-cycle ack latency
        do_run(2'd0, 1'b0);
        chk("m0_last_word", 32'(mem[15]), 32'h0F);
        do_run(2'd1, 1'b0);
        chk("m1_word0", 32'(mem[0]), 32'h55);
        chk("m1_word1", 32'(mem[1]), 32'hAA);
        stuck[5] = 8'h08;
        stuck[9] = 8'h08;
        do_run(2'd2, 1'b0);
        chk("m2_err_cnt",   32'(err_cnt_o), 32'd2);
        chk("m2_fail_addr", 32'(fail_addr_o), 32'd5);
        chk("m2_pass",      32'(pass_o), 32'd0);
        stuck[5] = 8'h00;
        stuck[9] = 8'h00;
        do_run(2'd3, 1'b0);

        // Ack on the same edge the wait counter reaches TIMEOUT
        lat_fix = TIMEOUT - 1;
        do_run(2'd0, 1'b0);

        // Slave stops acking at write address 3
        lat_fix = 1; stall_en = 1'b1; stall_addr = 3;
        n_wr = 0; n_done = 0;
        pulse_start(2'd0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_we_o && wb_addr_o == 4'd3) found = 1'b1;
        end
        chk("to_reach_addr3", 32'(found), 32'd1);
        run = 0;
        while (wb_cyc_o && run < 40) begin
            run++;
            @(negedge clk);
        end
        chk("to_cyc_cycles", 32'(run), 32'(TIMEOUT));
        chk("to_done",       32'(done_o), 32'd1);
        chk("to_flag",       32'(timeout_o), 32'd1);
        chk("to_pass",       32'(pass_o), 32'd0);
        chk("to_writes",     32'(n_wr), 32'd3);
        @(negedge clk);
        chk("to_done_width", 32'(done_o), 32'd0);
        chk("to_busy_idle",  32'(busy_o), 32'd0);
        chk("to_done_count", 32'(n_done), 32'd1);
        stall_en = 1'b0;

        // Everything corrupted: error counter saturates; start while busy ignored
        lat_fix = -1; corrupt = 1'b1;
        do_run(2'd1, 1'b1);
        chk("sat_err_cnt", 32'(err_cnt_o), 32'd3);
        corrupt = 1'b0;

        // Asynchronous reset in the middle of a read access
        pulse_start(2'd2);
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            @(negedge clk);
            if (wb_cyc_o && !wb_we_o && wb_addr_o == 4'd6) found = 1'b1;
        end
        chk("rst_reach_rd", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async_outputs", 32'(all_outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(wb_cyc_o);
        end
        chk("rst_no_restart", 32'(cnt), 32'd0);
        do_run(2'd2, 1'b0);

        // Randomized runs with random faults and ack latencies
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++)
                stuck[a] = ($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
            do_run(2'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire
